// File: rtl/hall_emulator_pkg.sv
// Shared hall definitions: six-step code table, step index width, invalid codes and timer states.
// The motor driver imports the same invalid-code constants for its detection logic.
package hall_emulator_pkg;

    localparam int STEP_INDEX_WIDTH = 3;

    localparam logic [2:0] HALL_CODE_0 = 3'b001;
    localparam logic [2:0] HALL_CODE_1 = 3'b011;
    localparam logic [2:0] HALL_CODE_2 = 3'b010;
    localparam logic [2:0] HALL_CODE_3 = 3'b110;
    localparam logic [2:0] HALL_CODE_4 = 3'b100;
    localparam logic [2:0] HALL_CODE_5 = 3'b101;

    localparam logic [2:0] HALL_INVALID_HI = 3'b111;
    localparam logic [2:0] HALL_INVALID_LO = 3'b000;

    typedef enum logic {
        TIMER_IDLE = 1'b0,
        TIMER_RUN  = 1'b1
    } timer_state_t;

    function automatic logic [2:0] hall_code(input logic [STEP_INDEX_WIDTH-1:0] idx);
        logic [2:0] code;
        case (idx)
            3'd1:    code = HALL_CODE_1;
            3'd2:    code = HALL_CODE_2;
            3'd3:    code = HALL_CODE_3;
            3'd4:    code = HALL_CODE_4;
            3'd5:    code = HALL_CODE_5;
            default: code = HALL_CODE_0;
        endcase
        return code;
    endfunction

    // Forward walks 0..5 upward, reverse walks downward; both wrap modulo 6.
    function automatic logic [STEP_INDEX_WIDTH-1:0] next_index(
        input logic [STEP_INDEX_WIDTH-1:0] idx,
        input logic                        reverse
    );
        logic [STEP_INDEX_WIDTH-1:0] nxt;
        if (reverse) begin
            nxt = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
        end else begin
            nxt = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hall_emulator_step_timer.sv
// Step timer: latches the period, counts clocks in RUN and emits a one-cycle step tick
// on the last clock of each step.
module hall_step_timer
    import hall_emulator_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_enable,
    input  logic [PERIOD_WIDTH-1:0] i_period,
    output logic                    o_step_tick
);

    timer_state_t            r_state;
    timer_state_t            w_next_state;
    logic [PERIOD_WIDTH-1:0] r_timer;
    logic [PERIOD_WIDTH-1:0] w_timer_next;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    w_load_period;
    logic                    w_tick;

    // Dropping enable wins over a step finishing in the same cycle.
    always_comb begin
        w_next_state  = r_state;
        w_timer_next  = r_timer;
        w_load_period = 1'b0;
        w_tick        = 1'b0;
        case (r_state)
            TIMER_IDLE: begin
                w_timer_next  = '0;
                w_load_period = 1'b1;
                if (i_enable && (i_period != '0)) begin
                    w_next_state = TIMER_RUN;
                end
            end
            TIMER_RUN: begin
                if (!i_enable) begin
                    w_next_state = TIMER_IDLE;
                    w_timer_next = '0;
                end else if (r_timer == (r_period - 1'b1)) begin
                    w_tick        = 1'b1;
                    w_timer_next  = '0;
                    w_load_period = 1'b1;
                    if (i_period == '0) begin
                        w_next_state = TIMER_IDLE;
                    end
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: begin
                w_next_state = TIMER_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= TIMER_IDLE;
            r_timer  <= '0;
            r_period <= '0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_timer_next;
            if (w_load_period) begin
                r_period <= i_period;
            end
        end
    end

    assign o_step_tick = w_tick;

endmodule

// File: rtl/hall_emulator.sv
// Hall-sensor emulator top: step index, hall code register, step strobe and signed position.
// Define HALL_EMU_FAULT_EN to add the fault_inject port that forces hall=111 for one cycle.
module hall_emulator
    import hall_emulator_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    direction,
    input  logic [PERIOD_WIDTH-1:0] period,
`ifdef HALL_EMU_FAULT_EN
    input  logic                    fault_inject,
`endif
    output logic [2:0]              hall,
    output logic                    step_strobe,
    output logic [COUNT_WIDTH-1:0]  step_count
);

    logic [STEP_INDEX_WIDTH-1:0] r_index;
    logic [2:0]                  r_hall;
    logic                        r_strobe;
    logic [COUNT_WIDTH-1:0]      r_count;
    logic                        w_step_tick;
    logic [STEP_INDEX_WIDTH-1:0] w_next_index;
    logic [2:0]                  w_hall_next;

    hall_step_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_step_timer (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_enable    (enable),
        .i_period    (period),
        .o_step_tick (w_step_tick)
    );

    assign w_next_index = next_index(r_index, direction);

    // The override only masks the displayed code; the index keeps advancing underneath.
    always_comb begin
        w_hall_next = hall_code(w_step_tick ? w_next_index : r_index);
`ifdef HALL_EMU_FAULT_EN
        if (fault_inject) begin
            w_hall_next = HALL_INVALID_HI;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_index  <= '0;
            r_hall   <= HALL_CODE_0;
            r_strobe <= 1'b0;
            r_count  <= '0;
        end else begin
            r_strobe <= w_step_tick;
            r_hall   <= w_hall_next;
            if (w_step_tick) begin
                r_index <= w_next_index;
                r_count <= direction ? (r_count - 1'b1) : (r_count + 1'b1);
            end
        end
    end

    assign hall        = r_hall;
    assign step_strobe = r_strobe;
    assign step_count  = r_count;

endmodule

// File: tb/tb_hall_emulator.sv
// Self-checking bench for hall_emulator: directed scenarios plus randomized stimulus
// against a cycle-level behavioural model of the six-step sequence.
module tb_hall_emulator;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        direction = 1'b0;
    logic [15:0] period = 16'd0;
    logic        faultInject = 1'b0;
    logic [2:0]  hall;
    logic        step_strobe;
    logic [15:0] step_count;

    int errorCount = 0;
    int checkCount = 0;

`ifdef HALL_EMU_FAULT_EN
    localparam bit FAULT_BUILD = 1'b1;
`else
    localparam bit FAULT_BUILD = 1'b0;
`endif

    hall_emulator #(
        .PERIOD_WIDTH (16),
        .COUNT_WIDTH  (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .direction    (direction),
        .period       (period),
`ifdef HALL_EMU_FAULT_EN
        .fault_inject (faultInject),
`endif
        .hall         (hall),
        .step_strobe  (step_strobe),
        .step_count   (step_count)
    );

    always #5 clock = ~clock;

    // Reference model: elapsed clocks since the step began versus the latched period.
    logic [2:0]  hallCodes [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    int          mCycle = 0;
    int          mStart = 0;
    int          mIdx = 0;
    bit          mRunning = 1'b0;
    logic [15:0] mLatched = 16'd0;
    logic [15:0] mCount = 16'd0;
    logic        mStrobe = 1'b0;
    logic [2:0]  mHall = 3'b001;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, mCycle);
        end
    endtask

    task automatic modelEdge();
        mCycle++;
        if (!reset_n) begin
            mIdx = 0;
            mCount = 16'd0;
            mStrobe = 1'b0;
            mRunning = 1'b0;
            mLatched = 16'd0;
            mHall = 3'b001;
            return;
        end
        mStrobe = 1'b0;
        if (!mRunning) begin
            mLatched = period;
            if (enable && period != 16'd0) begin
                mRunning = 1'b1;
                mStart = mCycle;
            end
        end else if (!enable) begin
            mRunning = 1'b0;
        end else if ((mCycle - mStart) == int'(mLatched)) begin
            mIdx = (mIdx + (direction ? 5 : 1)) % 6;
            mCount = direction ? mCount - 16'd1 : mCount + 16'd1;
            mStrobe = 1'b1;
            mStart = mCycle;
            mLatched = period;
            if (period == 16'd0) mRunning = 1'b0;
        end
        mHall = faultInject ? 3'b111 : hallCodes[mIdx];
    endtask

    task automatic applyStimulus(input bit rstN, input bit en, input bit dir,
                                 input logic [15:0] per, input bit flt);
        reset_n = rstN;
        enable = en;
        direction = dir;
        period = per;
        faultInject = flt & FAULT_BUILD;
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput("hall", 32'(hall), 32'(mHall));
        checkOutput("step_strobe", 32'(step_strobe), 32'(mStrobe));
        checkOutput("step_count", 32'(step_count), 32'(mCount));
    endtask

    initial begin
        int  cycles;
        bit  dir;
        logic [15:0] per;

        repeat (3) applyStimulus(0, 0, 0, 16'd0, 0);
        checkOutput("resetHall", 32'(hall), 32'h1);
        checkOutput("resetCount", 32'(step_count), 32'h0);
        checkOutput("resetStrobe", 32'(step_strobe), 32'h0);

        cycles = 0;
        do begin
            applyStimulus(1, 1, 0, 16'd4, 0);
            cycles++;
        end while (!step_strobe && cycles < 20);
        checkOutput("firstStrobeLatency", 32'(cycles), 32'd5);
        repeat (30) applyStimulus(1, 1, 0, 16'd4, 0);

        applyStimulus(0, 0, 0, 16'd0, 0);
        repeat (20) applyStimulus(1, 1, 1, 16'd2, 0);

        applyStimulus(0, 0, 0, 16'd0, 0);
        repeat (3) applyStimulus(1, 1, 0, 16'd10, 0);
        repeat (25) applyStimulus(1, 1, 0, 16'd3, 0);

        applyStimulus(0, 0, 0, 16'd0, 0);
        repeat (5) applyStimulus(1, 1, 0, 16'd5, 0);
        applyStimulus(1, 0, 0, 16'd5, 0);
        repeat (12) applyStimulus(1, 1, 0, 16'd5, 0);

        applyStimulus(0, 0, 0, 16'd0, 0);
        cycles = 0;
        while (!(hall == 3'b110 && step_count == 16'd3) && cycles < 50) begin
            applyStimulus(1, 1, 0, 16'd2, 0);
            cycles++;
        end
        checkOutput("reachedHall110", 32'(hall), 32'h6);
        applyStimulus(0, 1, 0, 16'd2, 0);
        checkOutput("midRunResetHall", 32'(hall), 32'h1);
        checkOutput("midRunResetCount", 32'(step_count), 32'h0);
        checkOutput("midRunResetStrobe", 32'(step_strobe), 32'h0);

        repeat (3) applyStimulus(1, 1, 1, 16'd1, 0);
        checkOutput("reverseWrapStrobe", 32'(step_strobe), 32'h1);

        applyStimulus(0, 0, 0, 16'd0, 0);
        cycles = 0;
        while (step_count != 16'h7FFF && cycles < 33000) begin
            applyStimulus(1, 1, 0, 16'd1, 0);
            cycles++;
        end
        checkOutput("reached7FFF", 32'(step_count), 32'h7FFF);
        applyStimulus(1, 1, 0, 16'd1, 0);
        checkOutput("forwardWrap", 32'(step_count), 32'h8000);

        if (FAULT_BUILD) begin
            applyStimulus(0, 0, 0, 16'd0, 0);
            repeat (14) applyStimulus(1, 1, 0, 16'd8, 0);
            applyStimulus(1, 1, 0, 16'd8, 1);
            checkOutput("faultForced", 32'(hall), 32'h7);
            repeat (20) applyStimulus(1, 1, 0, 16'd8, 0);
        end

        dir = 1'b0;
        per = 16'd3;
        applyStimulus(0, 0, 0, 16'd0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 15) == 0) per = 16'($urandom_range(0, 6));
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0, dir, per,
                          $urandom_range(0, 29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
